order_entry_tx: RTL and testbench

Order-entry transmitter for the NanoTrade order book. It accepts buy/sell requests from the host-side logic over a valid/ready handshake and buffers them in a small FIFO. It drives them onto the order book's order bus (`input_type`/`data_in`/`ext_data`) only on cycles the book will actually consume them, so no order is lost while the circuit breaker halts or throttles the book. It also keeps sent/rejected/flushed counters for the status readback path.

---
 rtl/nanotrade_pkg.sv | 8 +
 rtl/order_fifo.sv | 45 ++++
 rtl/order_entry_tx.sv | 77 +++++++
 tb/tb_order_entry_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/nanotrade_pkg.sv
// nanotrade_pkg: order-bus encodings, price limit and transmitter state shared across NanoTrade blocks
package nanotrade_pkg;
    localparam logic [1:0] OT_IDLE = 2'b00;
    localparam logic [1:0] OT_BUY  = 2'b10;
    localparam logic [1:0] OT_SELL = 2'b11;
    localparam logic [6:0] MAX_PRICE = 7'd63;
    typedef enum logic [1:0] {RUN, HALTED, FLUSHING} state_t;
endpackage

// File: rtl/order_fifo.sv
// order_fifo: synchronous FIFO with push/pop/clear, full/empty and occupancy count
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= i_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/order_entry_tx.sv
// order_entry_tx: queues host orders and drives them onto the book's order bus
// only on cycles the circuit-breaker gate lets the book consume them.
module order_entry_tx
    import nanotrade_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit HALT_FLUSH = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_side,
    input  logic [6:0] req_price,
    output logic       req_ready,
    input  logic       cb_halt,
    input  logic       cb_throttle,
    input  logic       cb_throttle_phase,
    output logic [1:0] input_type,
    output logic [5:0] data_in,
    output logic [5:0] ext_data,
    output logic [7:0] sent_cnt,
    output logic [7:0] reject_cnt,
    output logic [7:0] flush_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t r_state;
    logic r_halt_d;
    logic [7:0] r_sent, r_rej, r_flush;
    logic w_full, w_empty, w_active, w_send, w_accept, w_push, w_flush, w_halt_rise;
    logic [6:0] w_head;
    logic [CW-1:0] w_count;

    assign w_flush     = r_state == FLUSHING;
    assign w_halt_rise = cb_halt && !r_halt_d;
    assign w_active    = !cb_halt && (!cb_throttle || cb_throttle_phase);
    assign w_send      = !w_empty && w_active && !w_flush;
    // no path from the pop side into req_ready, so a full FIFO always stalls the host
    assign req_ready   = !rst && !w_full && !w_flush && !(HALT_FLUSH && cb_halt);
    assign w_accept    = req_valid && req_ready;
    assign w_push      = w_accept && req_price <= MAX_PRICE;

    assign input_type = w_send ? (w_head[6] ? OT_SELL : OT_BUY) : OT_IDLE;
    assign data_in    = w_send ? {w_head[4:0], 1'b0} : 6'd0;
    assign ext_data   = w_send ? {5'd0, w_head[5]} : 6'd0;
    assign sent_cnt   = r_sent;
    assign reject_cnt = r_rej;
    assign flush_cnt  = r_flush;

    order_fifo #(.DEPTH(DEPTH), .W(7)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({req_side, req_price[5:0]}),
        .i_pop   (w_send),
        .i_clear (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_halt_d <= 1'b0;
            r_sent   <= '0;
            r_rej    <= '0;
            r_flush  <= '0;
        end else begin
            r_state  <= w_halt_rise ? (HALT_FLUSH ? FLUSHING : HALTED) : (cb_halt ? HALTED : RUN);
            r_halt_d <= cb_halt;
            r_sent   <= r_sent + 8'(w_send);
            r_rej    <= r_rej + 8'(w_accept && !w_push);
            r_flush  <= w_flush ? r_flush + 8'(w_count) : r_flush;
        end
    end
endmodule

// File: tb/tb_order_entry_tx.sv
// tb_order_entry_tx: randomized check of retain and flush variants against a queue-level order model
module tb_order_entry_tx;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_side = 1'b0;
    logic [6:0] req_price = 7'd0;
    logic cb_halt = 1'b0, cb_throttle = 1'b0, cb_throttle_phase = 1'b0;
    logic rdy [2];
    logic [1:0] ityp [2];
    logic [5:0] din [2], ext [2];
    logic [7:0] sc [2], rc [2], fc [2];
    int n_chk = 0, n_bad = 0;
    logic [6:0] mq [2][16];
    int mn [2];
    logic [7:0] ms [2], mr [2], mf [2];
    bit mfl [2];
    bit mhd;
    int hold = 0;

    always #5 clk = ~clk;

    order_entry_tx #(.DEPTH(D), .HALT_FLUSH(1'b0)) u_ret (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_side(req_side), .req_price(req_price),
        .req_ready(rdy[0]), .cb_halt(cb_halt), .cb_throttle(cb_throttle),
        .cb_throttle_phase(cb_throttle_phase), .input_type(ityp[0]), .data_in(din[0]),
        .ext_data(ext[0]), .sent_cnt(sc[0]), .reject_cnt(rc[0]), .flush_cnt(fc[0])
    );
    order_entry_tx #(.DEPTH(D), .HALT_FLUSH(1'b1)) u_fl (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_side(req_side), .req_price(req_price),
        .req_ready(rdy[1]), .cb_halt(cb_halt), .cb_throttle(cb_throttle),
        .cb_throttle_phase(cb_throttle_phase), .input_type(ityp[1]), .data_in(din[1]),
        .ext_data(ext[1]), .sent_cnt(sc[1]), .reject_cnt(rc[1]), .flush_cnt(fc[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset;
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; ms[k] = 8'd0; mr[k] = 8'd0; mf[k] = 8'd0; mfl[k] = 1'b0;
        end
        mhd = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_bus%0d", tag, k), {17'd0, rdy[k], ityp[k], din[k], ext[k]}, 32'd0);
            chk($sformatf("%s_cnt%0d", tag, k), {8'd0, sc[k], rc[k], fc[k]}, 32'd0);
        end
    endtask

    // expected behaviour this cycle, then advance the model across the coming edge
    task automatic cycle_check;
        bit act, snd, erdy;
        logic [6:0] h;
        logic [13:0] ebus;
        act = !cb_halt && (!cb_throttle || cb_throttle_phase);
        for (int k = 0; k < 2; k++) begin
            erdy = (mn[k] < D) && !mfl[k] && !(k == 1 && cb_halt);
            snd = (mn[k] > 0) && act && !mfl[k];
            h = mq[k][0];
            ebus = snd ? {1'b1, h[6], h[4:0], 1'b0, 5'd0, h[5]} : 14'd0;
            chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(erdy));
            chk($sformatf("bus%0d", k), 32'({ityp[k], din[k], ext[k]}), 32'(ebus));
            chk($sformatf("sent%0d", k), 32'(sc[k]), 32'(ms[k]));
            chk($sformatf("rej%0d", k), 32'(rc[k]), 32'(mr[k]));
            chk($sformatf("flush%0d", k), 32'(fc[k]), 32'(mf[k]));
            if (mfl[k]) begin
                mf[k] = mf[k] + 8'(mn[k]);
                mn[k] = 0;
            end
            if (snd) begin
                for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
                mn[k]--;
                ms[k]++;
            end
            if (req_valid && erdy) begin
                if (req_price > 7'd63) mr[k]++;
                else begin
                    mq[k][mn[k]] = {req_side, req_price[5:0]};
                    mn[k]++;
                end
            end
            mfl[k] = (k == 1) && cb_halt && !mhd;
        end
        mhd = cb_halt;
    endtask

    task automatic drive(input int c);
        int mode;
        mode = (c / 50) % 5;
        req_valid = (mode == 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
        req_side = 1'($urandom);
        req_price = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63));
        cb_throttle = (mode == 1) ? 1'b1 : (mode == 3) ? 1'($urandom) : 1'b0;
        cb_throttle_phase = (mode == 1) ? ~cb_throttle_phase : 1'($urandom);
        if (mode == 2) begin
            if (hold == 0) begin
                cb_halt = ~cb_halt;
                hold = cb_halt ? $urandom_range(1, 4) : $urandom_range(1, 8);
            end
            hold--;
        end else if (mode == 4) cb_halt = (c % 50) < 30;
        else if (mode == 3) cb_halt = ($urandom_range(0, 7) == 0);
        else cb_halt = 1'b0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            drive(c);
            @(negedge clk);
            cycle_check;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid_reset;
        req_valid = 1'b1; req_price = 7'd20; req_side = 1'b0;
        cb_halt = 1'b1; cb_throttle = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cycle_check;
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1 check_idle("midrst");
        model_reset;
        req_valid = 1'b0; cb_halt = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            cycle_check;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        model_reset;
        #1 check_idle("rst0");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        run(1200);
        mid_reset;
        run(1200);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
